// File: rtl/frame_timing_generator.sv
// -----------------------------------------------------------------------------
// frame_timing_generator
//
// Parametrised raster timing generator at the head of the video pipeline.
// Keeps a horizontal pixel counter (hCount) and a vertical line counter
// (vCount). From these it derives the sync pulses, the active-video flag,
// look-ahead strobes for the fetch/render stages and scaled pixel coordinates.
// It also provides a run/stop enable, a completed-frame counter and a sticky
// raster-line interrupt.
//
// Ports
//   clkPixel        in   pixel clock
//   resetN          in   asynchronous active-low reset
//   enable          in   1 = run, 0 = counters held at 0 and syncs inactive
//   irqLine         in   raster-interrupt compare line (raw vCount units)
//   irqAck          in   clears irqPending on the next edge
//   hsync           out  registered horizontal sync, polarity per HSYNC_POS
//   vsync           out  registered vertical sync, polarity per VSYNC_POS
//   videoActive     out  visible pixel of a visible line while enabled
//   lineStarting    out  strobe PIPELINE_DELAY pixels before the line wraps
//   lineEnding      out  strobe PIPELINE_DELAY pixels before the last visible pixel
//   hsyncStarting   out  strobe PIPELINE_DELAY pixels before hsync asserts
//   vsyncStarting   out  strobe on the last pixel before vsync asserts
//   hPos            out  hCount >> H_SHIFT on visible pixels, else 0
//   vPos            out  vCount >> V_SHIFT on visible lines, else 0
//   nextFrameActive out  the line held in nextVCount is visible
//   nextVPos        out  nextVCount >> V_SHIFT when nextFrameActive, else 0
//   frameCount      out  completed-frame counter (wraps)
//   irqPending      out  sticky raster interrupt flag
// -----------------------------------------------------------------------------
module frame_timing_generator #(
    parameter int H_VISIBLE      = 320,
    parameter int H_FP           = 8,
    parameter int H_SYNC         = 48,
    parameter int H_BP           = 24,
    parameter int V_VISIBLE      = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int HSYNC_POS      = 0,
    parameter int VSYNC_POS      = 0,
    parameter int H_SHIFT        = 0,
    parameter int V_SHIFT        = 1,
    parameter int PIPELINE_DELAY = 0,
    parameter int FC_WIDTH       = 8,
    localparam int H_TOTAL       = H_VISIBLE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL       = V_VISIBLE + V_FP + V_SYNC + V_BP,
    localparam int HW            = $clog2(H_TOTAL),
    localparam int VW            = $clog2(V_TOTAL)
) (
    input  logic                clkPixel,
    input  logic                resetN,
    input  logic                enable,
    input  logic [VW-1:0]       irqLine,
    input  logic                irqAck,
    output logic                hsync,
    output logic                vsync,
    output logic                videoActive,
    output logic                lineStarting,
    output logic                lineEnding,
    output logic                hsyncStarting,
    output logic                vsyncStarting,
    output logic [HW-1:0]       hPos,
    output logic [VW-1:0]       vPos,
    output logic                nextFrameActive,
    output logic [VW-1:0]       nextVPos,
    output logic [FC_WIDTH-1:0] frameCount,
    output logic                irqPending
);

    // Horizontal landmarks (all fit in HW bits because each is < H_TOTAL).
    localparam logic [HW-1:0] H_LAST         = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS          = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_VIS_LAST     = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] HSYNC_FIRST    = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HSYNC_LAST     = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] LINE_START_AT  = HW'(H_TOTAL - 1 - PIPELINE_DELAY);
    localparam logic [HW-1:0] LINE_END_AT    = HW'(H_VISIBLE - 1 - PIPELINE_DELAY);
    localparam logic [HW-1:0] HSYNC_START_AT = HW'(H_VISIBLE + H_FP - 1 - PIPELINE_DELAY);

    // Vertical landmarks.
    localparam logic [VW-1:0] V_LAST         = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS          = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VSYNC_FIRST    = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VSYNC_LAST     = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] VSYNC_PREV     = VW'(V_VISIBLE + V_FP - 1);

    // Active levels of the sync outputs.
    localparam logic HSYNC_ON = (HSYNC_POS != 0) ? 1'b1 : 1'b0;
    localparam logic VSYNC_ON = (VSYNC_POS != 0) ? 1'b1 : 1'b0;

    logic [HW-1:0]       hCount_r;
    logic [VW-1:0]       vCount_r;
    logic [VW-1:0]       nextVCount_r;
    logic                hsync_r;
    logic                vsync_r;
    logic [HW-1:0]       hPos_r;
    logic [VW-1:0]       vPos_r;
    logic                nextFrameActive_r;
    logic [VW-1:0]       nextVPos_r;
    logic [FC_WIDTH-1:0] frameCount_r;
    logic                irqPending_r;

    logic [HW-1:0]       hCountNext_s;
    logic [VW-1:0]       vCountNext_s;
    logic [VW-1:0]       nextVCountNext_s;
    logic                hsyncNext_s;
    logic                vsyncNext_s;
    logic                frameDone_s;
    logic                irqSet_s;

    // Next counter values; every registered output is derived from these so
    // that it lines up with the counters with zero skew.
    always_comb begin
        hCountNext_s     = {HW{1'b0}};
        vCountNext_s     = {VW{1'b0}};
        nextVCountNext_s = {VW{1'b0}};
        if (!enable) begin
            hCountNext_s     = {HW{1'b0}};
            vCountNext_s     = {VW{1'b0}};
            nextVCountNext_s = {VW{1'b0}};
        end else begin
            if (hCount_r == H_LAST) begin
                hCountNext_s = {HW{1'b0}};
                vCountNext_s = nextVCount_r;
            end else begin
                hCountNext_s = hCount_r + HW'(1);
                vCountNext_s = vCount_r;
            end
            // nextVCount is prepared at the end of the visible area so it is
            // stable through the whole blanking interval of the line.
            if (hCount_r == H_VIS_LAST) begin
                if (vCount_r == V_LAST) begin
                    nextVCountNext_s = {VW{1'b0}};
                end else begin
                    nextVCountNext_s = vCount_r + VW'(1);
                end
            end else begin
                nextVCountNext_s = nextVCount_r;
            end
        end
    end

    // Sync windows, frame completion and interrupt set conditions.
    always_comb begin
        hsyncNext_s = (hCountNext_s >= HSYNC_FIRST) && (hCountNext_s <= HSYNC_LAST);
        vsyncNext_s = (vCountNext_s >= VSYNC_FIRST) && (vCountNext_s <= VSYNC_LAST);
        frameDone_s = enable && (hCount_r == H_LAST) && (vCount_r == V_LAST);
        // irqLine values beyond the frame never match nextVCount.
        irqSet_s    = enable && (hCount_r == H_LAST) && (nextVCount_r == irqLine);
    end

    // Counters, syncs, coordinates, frame counter and interrupt flag.
    always_ff @(posedge clkPixel or negedge resetN) begin
        if (!resetN) begin
            hCount_r          <= {HW{1'b0}};
            vCount_r          <= {VW{1'b0}};
            nextVCount_r      <= {VW{1'b0}};
            hsync_r           <= ~HSYNC_ON;
            vsync_r           <= ~VSYNC_ON;
            hPos_r            <= {HW{1'b0}};
            vPos_r            <= {VW{1'b0}};
            // nextVCount resets to line 0, which is a visible line.
            nextFrameActive_r <= (V_VISIBLE > 0) ? 1'b1 : 1'b0;
            nextVPos_r        <= {VW{1'b0}};
            frameCount_r      <= {FC_WIDTH{1'b0}};
            irqPending_r      <= 1'b0;
        end else begin
            hCount_r          <= hCountNext_s;
            vCount_r          <= vCountNext_s;
            nextVCount_r      <= nextVCountNext_s;
            hsync_r           <= hsyncNext_s ? HSYNC_ON : ~HSYNC_ON;
            vsync_r           <= vsyncNext_s ? VSYNC_ON : ~VSYNC_ON;
            hPos_r            <= (hCountNext_s < H_VIS) ? (hCountNext_s >> H_SHIFT) : {HW{1'b0}};
            vPos_r            <= (vCountNext_s < V_VIS) ? (vCountNext_s >> V_SHIFT) : {VW{1'b0}};
            nextFrameActive_r <= (nextVCountNext_s < V_VIS);
            nextVPos_r        <= (nextVCountNext_s < V_VIS) ? (nextVCountNext_s >> V_SHIFT) : {VW{1'b0}};
            if (frameDone_s) begin
                frameCount_r <= frameCount_r + FC_WIDTH'(1);
            end else begin
                frameCount_r <= frameCount_r;
            end
            // A set on the same edge as an ack wins.
            if (irqSet_s) begin
                irqPending_r <= 1'b1;
            end else if (irqAck) begin
                irqPending_r <= 1'b0;
            end else begin
                irqPending_r <= irqPending_r;
            end
        end
    end

    assign hsync           = hsync_r;
    assign vsync           = vsync_r;
    assign hPos            = hPos_r;
    assign vPos            = vPos_r;
    assign nextFrameActive = nextFrameActive_r;
    assign nextVPos        = nextVPos_r;
    assign frameCount      = frameCount_r;
    assign irqPending      = irqPending_r;

    // Strobes decode the current counters directly; resetN gating keeps them
    // quiet while reset is held.
    assign videoActive   = resetN && enable && (hCount_r < H_VIS) && (vCount_r < V_VIS);
    assign lineStarting  = resetN && (hCount_r == LINE_START_AT);
    assign lineEnding    = resetN && (hCount_r == LINE_END_AT);
    assign hsyncStarting = resetN && (hCount_r == HSYNC_START_AT);
    assign vsyncStarting = resetN && (hCount_r == H_LAST) && (vCount_r == VSYNC_PREV);

endmodule

// File: doc/frame_timing_generator.md
Name: frame_timing_generator

Overview:
Parametrised successor to the fixed 320x480 pixel-clock frame generator. Produces hsync/vsync, active-video and look-ahead strobes, and scaled pixel coordinates from fully parametrised timing. Adds a run/stop enable, a frame counter and a sticky raster-line interrupt. Sits at the head of the video pipeline, driving the fetch/render stages and the display PHY.

Parameters:
H_VISIBLE, 320, visible pixels per line
H_FP, 8, horizontal front porch (pixels)
H_SYNC, 48, hsync width (pixels)
H_BP, 24, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POS, 0, 1 = hsync active-high, 0 = active-low
VSYNC_POS, 0, 1 = vsync active-high, 0 = active-low
H_SHIFT, 0, hPos = hCount >> H_SHIFT (pixel replication)
V_SHIFT, 1, vPos = vCount >> V_SHIFT (line replication)
PIPELINE_DELAY, 0, advance of lineStarting/lineEnding/hsyncStarting in pixels; legal range 0..H_FP-1
FC_WIDTH, 8, frameCount width
Derived: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL)

Ports:
clkPixel  in  1  pixel clock
resetN  in  1  asynchronous active-low reset
enable  in  1  run when 1; when 0, counters held at 0
irqLine  in  VW  raster-interrupt compare line (raw vCount units)
irqAck  in  1  clears irqPending
hsync  out  1  registered horizontal sync, polarity per HSYNC_POS
vsync  out  1  registered vertical sync, polarity per VSYNC_POS
videoActive  out  1  hCount < H_VISIBLE and vCount < V_VISIBLE and enable
lineStarting  out  1  1-cycle strobe at hCount == H_TOTAL-1-PIPELINE_DELAY
lineEnding  out  1  1-cycle strobe at hCount == H_VISIBLE-1-PIPELINE_DELAY
hsyncStarting  out  1  1-cycle strobe at hCount == H_VISIBLE+H_FP-1-PIPELINE_DELAY
vsyncStarting  out  1  1-cycle strobe at hCount == H_TOTAL-1 and vCount == V_VISIBLE+V_FP-1
hPos  out  HW  hCount >> H_SHIFT while line active, else 0
vPos  out  VW  vCount >> V_SHIFT while frame active, else 0
nextFrameActive  out  1  nextVCount < V_VISIBLE
nextVPos  out  VW  nextVCount >> V_SHIFT if nextFrameActive, else 0
frameCount  out  FC_WIDTH  completed-frame counter
irqPending  out  1  sticky raster interrupt flag

Behaviour:
- Reset (resetN low, asynchronous): hCount = vCount = nextVCount = 0; hsync = ~HSYNC_POS; vsync = ~VSYNC_POS; frameCount = 0; irqPending = 0. All strobes and videoActive are forced 0 while resetN is low.
- enable low: on each edge, hCount, vCount and nextVCount load 0 and hsync/vsync load their inactive levels. frameCount and irqPending hold. The first enabled edge advances from (0,0) to hCount = 1.
- hCount counts 0..H_TOTAL-1, then wraps to 0. On wrap, vCount loads nextVCount.
- nextVCount loads (vCount == V_TOTAL-1 ? 0 : vCount+1) on the edge where hCount == H_VISIBLE-1. It is stable from the first front-porch pixel through the end of the line.
- hsync flop is aligned with hCount: it is active for exactly the cycles with H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC, implemented by registering the comparison on the next hCount value. Zero skew to hPos.
- vsync flop is aligned with vCount: it is active for all cycles with V_VISIBLE+V_FP <= vCount < V_VISIBLE+V_FP+V_SYNC, changing on the hCount wrap edge.
- Strobes are combinational from the counters, single-cycle, and fire once per line (vsyncStarting once per frame).
- frameCount increments on the edge where hCount == H_TOTAL-1 and vCount == V_TOTAL-1. It wraps modulo 2^FC_WIDTH.
- irqPending sets on the edge where hCount == H_TOTAL-1 and nextVCount == irqLine, so it is visible on pixel 0 of line irqLine. irqAck high clears it on the next edge. A simultaneous set and ack leaves it set. If irqLine >= V_TOTAL, it never sets.
- Latency: all outputs are consistent with the current counter values. hPos and vPos require no external pipeline compensation beyond PIPELINE_DELAY.

Test Plan:
- Defaults, release reset with enable=1 -> hsync=vsync=1 in reset; line period 400 clocks; hsync low for hCount 328..375 (48 clocks); vsync low for vCount 490..491; frame period 210000 clocks.
- Defaults, vCount 10, hCount 100 -> hPos=100, vPos=5, videoActive=1; at hCount 320, hPos=0, nextVPos=5 (nextVCount 11).
- PIPELINE_DELAY=4 -> lineEnding at hCount 315, hsyncStarting at 323, lineStarting at 395, each exactly 1 clock.
- irqLine=200, irqAck=0 -> irqPending rises at vCount=200, hCount=0; ack pulsed on the same edge as the next frame's set -> irqPending stays 1.
- FC_WIDTH=2, run 5 frames -> frameCount sequence 1,2,3,0,1, changing at each hCount=399/vCount=524 edge.
- resetN low mid-line (hCount 150, vCount 300) -> all outputs return to reset values immediately, without a clock edge. enable low for 10 clocks -> counters stay at 0 and frameCount holds.
